photonic_order_arbiter: RTL and testbench
=========================================

PHOTONIC_ORDER_ARBITER -- requirements
Module: photonic_order_arbiter

Interface
REQ-001 Parameter N_REQ, 4, number of order sources; legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, 512, maximum clk_156mhz cycles waited for an engine ack.
REQ-003 clk_156mhz  input  1  system clock, 156.25 MHz; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  N_REQ  per-source order pending.
REQ-006 req_data  input  N_REQ*128  per-source order word; source i occupies bits [128*i+127:128*i].
REQ-007 req_ready  output  N_REQ  one-cycle accept strobe per source.
REQ-008 src_done  output  N_REQ  one-cycle strobe to source i when its order is acked.
REQ-009 eng_order_data  output  128  order word to the engine.
REQ-010 eng_order_valid  output  1  one-cycle issue strobe to the engine.
REQ-011 eng_order_ack  input  1  engine completion strobe.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 grant_id  output  3  index of the source currently owning the engine.
REQ-014 timeout_err  output  1  sticky timeout flag.
REQ-015 err_src  output  3  source index of the most recent timeout.
REQ-016 err_clr  input  1  clears timeout_err.

Function
REQ-017 The FSM SHALL have four states: IDLE, ISSUE, WAIT_ACK and RECOVER.
REQ-018 IDLE with any req_valid set: round-robin select starting at last_grant+1 modulo N_REQ; assert req_ready[sel] for exactly that cycle; latch req_data[sel] into eng_order_data; set grant_id=sel; go to ISSUE.
REQ-019 IDLE with no req_valid set: remain in IDLE; all strobes low.
REQ-020 ISSUE: eng_order_valid=1 for one cycle; clear the wait counter to 0; go to WAIT_ACK.
REQ-021 Latency from req_valid sampled in IDLE to eng_order_valid high SHALL be exactly 2 cycles.
REQ-022 WAIT_ACK: increment the wait counter each cycle.
REQ-023 WAIT_ACK with eng_order_ack=1: assert src_done[grant_id] next cycle; set last_grant=grant_id; go to IDLE.
REQ-024 Counter reaching TIMEOUT_CYCLES-1 without an ack: set timeout_err=1 and err_src=grant_id; go to RECOVER.
REQ-025 Ack arriving on the same cycle the counter reaches TIMEOUT_CYCLES-1: the ack wins and no timeout is flagged.
REQ-026 RECOVER: wait one cycle so the engine can finish its ACK state; set last_grant=grant_id; return to IDLE; src_done is not asserted.
REQ-027 eng_order_ack seen outside WAIT_ACK SHALL be ignored.
REQ-028 eng_order_data and grant_id SHALL hold steady from ISSUE until the FSM returns to IDLE.
REQ-029 A source that deasserts req_valid while not granted SHALL simply lose arbitration; no state is kept for it.
REQ-030 err_clr and a new timeout on the same cycle: the timeout wins, so timeout_err stays 1.
REQ-031 The wait counter SHALL be $clog2(TIMEOUT_CYCLES)+1 bits wide and saturating; it never wraps.
REQ-032 The arbiter SHALL accept at most one order in flight.

Reset
REQ-033 Asserting reset_n low SHALL force state=IDLE and last_grant=N_REQ-1, so source 0 wins first.
REQ-034 Reset values: req_ready=0, src_done=0, eng_order_valid=0, busy=0, grant_id=0, eng_order_data=0, timeout_err=0, err_src=0, counter=0.
REQ-035 Reset asserted mid-WAIT_ACK SHALL abandon the order silently, with no src_done and no error.

Configuration
REQ-036 Macro ARB_LATENCY_STATS_EN defined: add outputs max_wait (16 bits) and order_count (32 bits).
REQ-037 max_wait holds the largest wait-counter value seen at any ack; order_count increments on each ack and wraps at 2^32; both reset to 0 and both are cleared by err_clr.
REQ-038 Macro ARB_LATENCY_STATS_EN undefined: these ports and their registers SHALL be absent; all other behaviour is identical.

Structure
REQ-039 Shared package photonic_pkg SHALL hold the FSM state enumeration, ORDER_W=128 and the default TIMEOUT_CYCLES constant.
REQ-040 Sub-module rr_arbiter (inputs: request vector, last_grant; outputs: one-hot grant and encoded index; purely combinational) SHALL be instantiated once.

Verification
REQ-041 Single request: req_valid=4'b0001, order 128'hA5 -> req_ready[0] on cycle 1; eng_order_valid on cycle 2 carrying 128'hA5; ack 130 cycles later -> src_done[0] one cycle later.
REQ-042 Fairness: req_valid=4'b1111 held and every order acked -> grant order 0,1,2,3,0,1; never two grants to one source back to back.
REQ-043 Timeout: grant source 2 and never ack -> timeout_err=1 and err_src=2 after 512 WAIT_ACK cycles; next grant goes to source 3; err_clr=1 clears the flag.
REQ-044 Boundary: ack on wait count 511 -> src_done asserted and timeout_err stays 0.
REQ-045 Reset mid-WAIT_ACK: reset_n low for 3 cycles -> all outputs at reset values, no src_done; the next grant goes to source 0.
REQ-046 Stats (ARB_LATENCY_STATS_EN): acks at wait counts 130, 200 and 150 -> max_wait=200 and order_count=3.

Source files
------------

// File: rtl/photonic_pkg.sv
// Shared definitions for the photonic order arbiter: FSM states, order word
// width, default engine-ack timeout and grant index width.
package photonic_pkg;

    localparam int ORDER_W                = 128;
    localparam int TIMEOUT_CYCLES_DEFAULT = 512;
    localparam int GRANT_W                = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2,
        RECOVER  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker. The search starts at last_grant+1 and wraps
// modulo N_REQ; the first pending request found wins.
module rr_arbiter
    import photonic_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [GRANT_W-1:0] last_grant,
    output logic [N_REQ-1:0]   grant_onehot,
    output logic [GRANT_W-1:0] grant_idx
);

    logic found_s;
    int   cand_s;

    // Walk the sources in rotating priority order and take the first request.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = {GRANT_W{1'b0}};
        found_s      = 1'b0;
        cand_s       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_s = int'(last_grant) + k;
            if (cand_s >= N_REQ) begin
                cand_s = cand_s - N_REQ;
            end else begin
                cand_s = cand_s;
            end
            for (int j = 0; j < N_REQ; j++) begin
                if (!found_s && (cand_s == j) && req[j]) begin
                    found_s         = 1'b1;
                    grant_onehot[j] = 1'b1;
                    grant_idx       = GRANT_W'(j);
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

endmodule

// File: rtl/photonic_order_arbiter.sv
// Photonic order arbiter: round-robin selection of one order source at a time,
// issue to the engine, wait for its ack with a saturating timeout counter, and
// report completion or a sticky timeout error.
// Optional feature macro: ARB_LATENCY_STATS_EN adds max_wait / order_count.
module photonic_order_arbiter
    import photonic_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                     clk_156mhz,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*ORDER_W-1:0] req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         src_done,
    output logic [ORDER_W-1:0]       eng_order_data,
    output logic                     eng_order_valid,
    input  logic                     eng_order_ack,
    output logic                     busy,
    output logic [GRANT_W-1:0]       grant_id,
    output logic                     timeout_err,
    output logic [GRANT_W-1:0]       err_src,
    input  logic                     err_clr
`ifdef ARB_LATENCY_STATS_EN
    ,
    output logic [15:0]              max_wait,
    output logic [31:0]              order_count
`endif
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    arb_state_e           state_q,       state_d;
    logic [GRANT_W-1:0]   last_grant_q,  last_grant_d;
    logic [GRANT_W-1:0]   grant_id_q,    grant_id_d;
    logic [ORDER_W-1:0]   order_data_q,  order_data_d;
    logic [N_REQ-1:0]     req_ready_q,   req_ready_d;
    logic [N_REQ-1:0]     src_done_q,    src_done_d;
    logic                 eng_valid_q,   eng_valid_d;
    logic                 busy_q,        busy_d;
    logic                 timeout_err_q, timeout_err_d;
    logic [GRANT_W-1:0]   err_src_q,     err_src_d;
    logic [CNT_W-1:0]     cnt_q,         cnt_d;

    logic [N_REQ-1:0]     arb_onehot_s;
    logic [GRANT_W-1:0]   arb_idx_s;
    logic [ORDER_W-1:0]   sel_data_s;
    logic                 timeout_set_s;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .req          (req_valid),
        .last_grant   (last_grant_q),
        .grant_onehot (arb_onehot_s),
        .grant_idx    (arb_idx_s)
    );

    // One-hot AND-OR mux of the winning source's order word.
    always_comb begin
        sel_data_s = {ORDER_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            sel_data_s = sel_data_s | (req_data[i*ORDER_W +: ORDER_W] & {ORDER_W{arb_onehot_s[i]}});
        end
    end

    // Next-state and next-output computation for the arbitration FSM.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_id_d    = grant_id_q;
        order_data_d  = order_data_q;
        req_ready_d   = '0;
        src_done_d    = '0;
        eng_valid_d   = 1'b0;
        err_src_d     = err_src_q;
        cnt_d         = cnt_q;
        timeout_set_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready_d  = arb_onehot_s;
                    order_data_d = sel_data_s;
                    grant_id_d   = arb_idx_s;
                    state_d      = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                eng_valid_d = 1'b1;
                cnt_d       = {CNT_W{1'b0}};
                state_d     = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
                // An ack on the final count still wins over the timeout.
                if (eng_order_ack) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        src_done_d[i] = (grant_id_q == GRANT_W'(i));
                    end
                    last_grant_d = grant_id_q;
                    state_d      = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_set_s = 1'b1;
                    err_src_d     = grant_id_q;
                    state_d       = RECOVER;
                end else begin
                    state_d = WAIT_ACK;
                end
            end
            RECOVER: begin
                // One quiet cycle lets the engine leave its ack phase.
                last_grant_d = grant_id_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A timeout on the same cycle as err_clr keeps the flag set.
        if (timeout_set_s) begin
            timeout_err_d = 1'b1;
        end else if (err_clr) begin
            timeout_err_d = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
        end

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset abandons any in-flight order silently.
    always_ff @(posedge clk_156mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            last_grant_q  <= GRANT_W'(N_REQ - 1);
            grant_id_q    <= {GRANT_W{1'b0}};
            order_data_q  <= {ORDER_W{1'b0}};
            req_ready_q   <= '0;
            src_done_q    <= '0;
            eng_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            err_src_q     <= {GRANT_W{1'b0}};
            cnt_q         <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_id_q    <= grant_id_d;
            order_data_q  <= order_data_d;
            req_ready_q   <= req_ready_d;
            src_done_q    <= src_done_d;
            eng_valid_q   <= eng_valid_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            err_src_q     <= err_src_d;
            cnt_q         <= cnt_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign src_done        = src_done_q;
    assign eng_order_data  = order_data_q;
    assign eng_order_valid = eng_valid_q;
    assign busy            = busy_q;
    assign grant_id        = grant_id_q;
    assign timeout_err     = timeout_err_q;
    assign err_src         = err_src_q;

`ifdef ARB_LATENCY_STATS_EN
    logic        ack_seen_s;
    logic [15:0] max_wait_q,    max_wait_d;
    logic [31:0] order_count_q, order_count_d;

    // Track the longest ack wait and the number of acked orders.
    always_comb begin
        ack_seen_s = (state_q == WAIT_ACK) && eng_order_ack;
        if (err_clr) begin
            max_wait_d    = 16'd0;
            order_count_d = 32'd0;
        end else if (ack_seen_s) begin
            if (16'(cnt_q) > max_wait_q) begin
                max_wait_d = 16'(cnt_q);
            end else begin
                max_wait_d = max_wait_q;
            end
            order_count_d = order_count_q + 32'd1;
        end else begin
            max_wait_d    = max_wait_q;
            order_count_d = order_count_q;
        end
    end

    // Latency statistics registers.
    always_ff @(posedge clk_156mhz or negedge reset_n) begin
        if (!reset_n) begin
            max_wait_q    <= 16'd0;
            order_count_q <= 32'd0;
        end else begin
            max_wait_q    <= max_wait_d;
            order_count_q <= order_count_d;
        end
    end

    assign max_wait    = max_wait_q;
    assign order_count = order_count_q;
`else
    // Statistics disabled: no extra ports or state.
`endif

endmodule

// File: tb/tb_photonic_order_arbiter.sv
// Self-checking bench for photonic_order_arbiter: table of directed
// transactions, hand-written corner sequences and randomized transactions
// checked against a transaction-level round-robin model.
module tb_photonic_order_arbiter;
    import photonic_pkg::*;

    localparam int N  = 4;
    localparam int TO = 512;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [N-1:0]       req_valid = '0;
    logic [N*128-1:0]   req_data = '0;
    logic [N-1:0]       req_ready;
    logic [N-1:0]       src_done;
    logic [127:0]       eng_order_data;
    logic               eng_order_valid;
    logic               eng_order_ack = 1'b0;
    logic               busy;
    logic [2:0]         grant_id;
    logic               timeout_err;
    logic [2:0]         err_src;
    logic               err_clr = 1'b0;
`ifdef ARB_LATENCY_STATS_EN
    logic [15:0]        max_wait;
    logic [31:0]        order_count;
`endif

    always #5 clk = ~clk;

    photonic_order_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk_156mhz      (clk),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .src_done        (src_done),
        .eng_order_data  (eng_order_data),
        .eng_order_valid (eng_order_valid),
        .eng_order_ack   (eng_order_ack),
        .busy            (busy),
        .grant_id        (grant_id),
        .timeout_err     (timeout_err),
        .err_src         (err_src),
        .err_clr         (err_clr)
`ifdef ARB_LATENCY_STATS_EN
        ,
        .max_wait        (max_wait),
        .order_count     (order_count)
`endif
    );

    int           total = 0;
    int           bad = 0;
    int           last_m;
    logic         terr_m;
    logic [2:0]   esrc_m;
    logic [127:0] word [N];

    typedef struct {
        logic [N-1:0] mask;
        int           wait_cnt;   // -1: never ack
        int           exp_sel;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] one;
        one = 1;
        return one << i;
    endfunction

    // Reference round-robin rule: first pending source after the last winner.
    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic load_words();
        for (int i = 0; i < N; i++) begin
            word[i] = {$urandom, $urandom, $urandom, $urandom};
            req_data[i*128 +: 128] = word[i];
        end
    endtask

    // One full order: request, issue, then ack at wait count w or time out.
    task automatic run_txn(input logic [N-1:0] mask, input int w, input int exp_sel, input bit clr_on_to);
        load_words();
        req_valid = mask;
        step();
        chk("req_ready", 128'(req_ready), 128'(oh(exp_sel)));
        chk("grant_id", 128'(grant_id), 128'(exp_sel));
        chk("busy_issue", 128'(busy), 128'(1'b1));
        chk("eov_early", 128'(eng_order_valid), 128'(1'b0));
        req_valid = '0;
        step();
        chk("eng_valid", 128'(eng_order_valid), 128'(1'b1));
        chk("eng_data", eng_order_data, word[exp_sel]);
        chk("req_ready_low", 128'(req_ready), 128'(0));
        if (w >= 0) begin
            repeat (w) begin
                step();
                chk("wait_eov", 128'(eng_order_valid), 128'(1'b0));
                chk("wait_done", 128'(src_done), 128'(0));
                chk("wait_grant", 128'(grant_id), 128'(exp_sel));
                chk("wait_data", eng_order_data, word[exp_sel]);
            end
            eng_order_ack = 1'b1;
            step();
            eng_order_ack = 1'b0;
            chk("src_done", 128'(src_done), 128'(oh(exp_sel)));
            chk("busy_after_ack", 128'(busy), 128'(1'b0));
            chk("terr_after_ack", 128'(timeout_err), 128'(terr_m));
            step();
            chk("src_done_strobe", 128'(src_done), 128'(0));
        end else begin
            repeat (TO - 1) begin
                step();
                chk("to_wait_terr", 128'(timeout_err), 128'(terr_m));
                chk("to_wait_busy", 128'(busy), 128'(1'b1));
            end
            if (clr_on_to) err_clr = 1'b1;
            step();
            err_clr = 1'b0;
            terr_m = 1'b1;
            esrc_m = 3'(exp_sel);
            chk("timeout_err", 128'(timeout_err), 128'(1'b1));
            chk("err_src", 128'(err_src), 128'(esrc_m));
            chk("recover_busy", 128'(busy), 128'(1'b1));
            chk("recover_done", 128'(src_done), 128'(0));
            step();
            chk("to_idle_busy", 128'(busy), 128'(1'b0));
            chk("to_no_done", 128'(src_done), 128'(0));
        end
        last_m = exp_sel;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 128'(req_ready), 128'(0));
        chk({tag, "_src_done"}, 128'(src_done), 128'(0));
        chk({tag, "_eov"}, 128'(eng_order_valid), 128'(1'b0));
        chk({tag, "_busy"}, 128'(busy), 128'(1'b0));
        chk({tag, "_grant"}, 128'(grant_id), 128'(0));
        chk({tag, "_data"}, eng_order_data, 128'(0));
        chk({tag, "_terr"}, 128'(timeout_err), 128'(1'b0));
        chk({tag, "_esrc"}, 128'(err_src), 128'(0));
    endtask

    initial begin
        int exp;
        int w;
        tbl[0]  = '{4'b0001, 130, 0};
        tbl[1]  = '{4'b1111,   3, 1};
        tbl[2]  = '{4'b1111,   0, 2};
        tbl[3]  = '{4'b1111,   5, 3};
        tbl[4]  = '{4'b1111,   1, 0};
        tbl[5]  = '{4'b1111,   2, 1};
        tbl[6]  = '{4'b0101,   4, 2};
        tbl[7]  = '{4'b0101, 511, 0};
        tbl[8]  = '{4'b1001,   7, 3};
        tbl[9]  = '{4'b0100,  -1, 2};
        tbl[10] = '{4'b1111,   2, 3};
        tbl[11] = '{4'b0010,   0, 1};

        last_m = N - 1;
        terr_m = 1'b0;
        esrc_m = 3'd0;

        // Power-on reset
        repeat (3) step();
        chk_reset_vals("reset");
        reset_n = 1'b1;
        step();

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run_txn(tbl[i].mask, tbl[i].wait_cnt, tbl[i].exp_sel, 1'b0);
        end

        // err_clr in IDLE clears the flag but keeps err_src
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        terr_m = 1'b0;
        chk("err_clr", 128'(timeout_err), 128'(1'b0));
        chk("err_src_kept", 128'(err_src), 128'(3'd2));

        // err_clr on the timeout cycle: timeout wins
        run_txn(4'b0001, -1, rr_pick(last_m, 4'b0001), 1'b1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        terr_m = 1'b0;
        chk("err_clr2", 128'(timeout_err), 128'(1'b0));

        // Ack during ISSUE is ignored
        exp = rr_pick(last_m, 4'b0011);
        load_words();
        req_valid = 4'b0011;
        step();
        req_valid = '0;
        eng_order_ack = 1'b1;
        step();
        eng_order_ack = 1'b0;
        chk("ign_eov", 128'(eng_order_valid), 128'(1'b1));
        step();
        chk("ign_busy", 128'(busy), 128'(1'b1));
        chk("ign_done", 128'(src_done), 128'(0));
        eng_order_ack = 1'b1;
        step();
        eng_order_ack = 1'b0;
        chk("ign_then_done", 128'(src_done), 128'(oh(exp)));
        last_m = exp;
        step();

        // Reset in the middle of WAIT_ACK
        load_words();
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        repeat (11) step();
        chk("pre_rst_busy", 128'(busy), 128'(1'b1));
        reset_n = 1'b0;
        repeat (3) begin
            step();
            chk_reset_vals("midrst");
        end
        reset_n = 1'b1;
        step();
        chk("post_rst_done", 128'(src_done), 128'(0));
        last_m = N - 1;
        terr_m = 1'b0;
        run_txn(4'b1111, 2, 0, 1'b0);

`ifdef ARB_LATENCY_STATS_EN
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("stats_clr_max", 128'(max_wait), 128'(0));
        chk("stats_clr_cnt", 128'(order_count), 128'(0));
        run_txn(4'b1111, 130, rr_pick(last_m, 4'b1111), 1'b0);
        run_txn(4'b1111, 200, rr_pick(last_m, 4'b1111), 1'b0);
        run_txn(4'b1111, 150, rr_pick(last_m, 4'b1111), 1'b0);
        chk("stats_max", 128'(max_wait), 128'(200));
        chk("stats_cnt", 128'(order_count), 128'(3));
`endif

        // Randomized transactions against the round-robin model
        for (int n = 0; n < 40; n++) begin
            logic [N-1:0] m;
            if ($urandom_range(0, 3) == 0) begin
                eng_order_ack = 1'b1;
                step();
                eng_order_ack = 1'b0;
                chk("idle_ack_done", 128'(src_done), 128'(0));
                chk("idle_ack_busy", 128'(busy), 128'(1'b0));
            end
            if (terr_m && $urandom_range(0, 1) == 1) begin
                err_clr = 1'b1;
                step();
                err_clr = 1'b0;
                terr_m = 1'b0;
                chk("rand_clr", 128'(timeout_err), 128'(1'b0));
            end
            m = N'($urandom_range(1, (1 << N) - 1));
            exp = rr_pick(last_m, m);
            if ($urandom_range(0, 19) == 0) w = -1;
            else w = $urandom_range(0, 40);
            run_txn(m, w, exp, 1'b0);
            chk("rand_terr", 128'(timeout_err), 128'(terr_m));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
